// File: rtl/rr_arbiter8_if.sv
// Handshake bundle between eight requesters, the round-robin arbiter and the
// single downstream consumer fed through the 8:1 select mux.
interface rr_arbiter8_if;
   logic [7:0] req;
   logic [7:0] req_rdy;
   logic [2:0] sel;
   logic [7:0] grant;
   logic       out_val;
   logic       out_rdy;

   modport master (
      input  req,
      input  out_rdy,
      output req_rdy,
      output sel,
      output grant,
      output out_val
   );

   modport slave (
      output req,
      output out_rdy,
      input  req_rdy,
      input  sel,
      input  grant,
      input  out_val
   );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter; grant, select and per-requester ready are combinational
// so a transfer completes in the same cycle the grant appears.
//
//   state | meaning
//   IDLE  | pick the first requester at or after ptr each cycle
//   HOLD  | downstream stalled; keep granting held_idx until out_rdy
module rr_arbiter8 #(
   parameter int p_reset_ptr = 0
) (
   input  logic          clk,
   input  logic          rst,
   rr_arbiter8_if.master bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] held_idx_q, held_idx_d;

   logic       win_found;
   logic [2:0] win_idx;
   logic       val_c;
   logic [2:0] sel_c;
   logic [7:0] grant_c;
   logic       xfer_c;

   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (!win_found && bus.req[ptr_q + 3'(k)]) begin
            win_found = 1'b1;
            win_idx   = ptr_q + 3'(k);
         end
      end
   end

   // Reset masks the outputs so a grant pending in HOLD cannot transfer.
   always_comb begin
      val_c   = 1'b0;
      sel_c   = 3'd0;
      grant_c = 8'd0;
      if (!rst) begin
         if (state_q == HOLD) begin
            val_c = 1'b1;
            sel_c = held_idx_q;
         end else begin
            val_c = win_found;
            sel_c = win_idx;
         end
         if (val_c) begin
            grant_c = 8'd1 << sel_c;
         end
      end
      xfer_c = val_c && bus.out_rdy;
   end

   assign bus.out_val = val_c;
   assign bus.sel     = sel_c;
   assign bus.grant   = grant_c;
   assign bus.req_rdy = xfer_c ? grant_c : 8'd0;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      held_idx_d = held_idx_q;
      if (xfer_c) begin
         ptr_d   = sel_c + 3'd1;
         state_d = IDLE;
      end else if (val_c && state_q == IDLE) begin
         state_d    = HOLD;
         held_idx_d = win_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 3'(p_reset_ptr);
         held_idx_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         held_idx_q <= held_idx_d;
      end
   end

endmodule
